// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared state type and bit-reverse helper for the FFT mux sequencer.
package fft_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  // Reverses the low w bits of v: full 32-bit reverse, then shift the result down.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r >> (32 - w);
  endfunction
endpackage

// File: rtl/fft_sync_fifo.sv
// fft_sync_fifo: single-clock FIFO with occupancy count, simultaneous push/pop.
module fft_sync_fifo #(
  parameter int W = 9,
  parameter int DEPTH = 4,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  assign pop_data = mem[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp <= wp == AW'(DEPTH - 1) ? '0 : wp + AW'(1);
      end
      if (do_pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: rtl/fft_mux_seq_ctrl.sv
// fft_mux_seq_ctrl: walks an external N:1 mux through a frame (linear or bit-reversed)
// and streams the returned samples out with credit-based flow control.
module fft_mux_seq_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_W = 8,
  parameter int MUX_LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  bitrev_i,
  output logic [SEL_W-1:0]      sel_o,
  input  logic [DATA_WIDTH-1:0] mux_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t state, state_nx;
  logic [SEL_W-1:0] cnt;
  logic rev, issue, pop, empty, accept;
  logic [MUX_LAT-1:0] sr_v, sr_l;
  logic [CW-1:0] occ;
  logic [DATA_WIDTH:0] head;
  assign sel_o = rev ? SEL_W'(bit_rev(32'(cnt), SEL_W)) : cnt;
  assign busy_o = state != IDLE;
  assign m_valid_o = ~empty;
  assign m_data_o = head[DATA_WIDTH-1:0];
  assign m_last_o = m_valid_o & head[DATA_WIDTH];
  assign pop = m_valid_o & m_ready_i;
  assign accept = state == IDLE && start_i;
  // Credit rule: buffered plus in-flight samples can never exceed the FIFO.
  always_comb begin
    issue = state == RUN && (int'(occ) + $countones(sr_v) < FIFO_DEPTH);
    state_nx = state == IDLE ? (start_i ? RUN : IDLE)
             : state == RUN  ? (issue && &cnt ? DRAIN : RUN)
             : (pop && m_last_o ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rev <= 1'b0;
      sr_v <= '0;
      sr_l <= '0;
      done_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= '0;
        rev <= bitrev_i;
      end else if (issue) cnt <= cnt + SEL_W'(1);
      sr_v <= MUX_LAT'({sr_v, issue});
      sr_l <= MUX_LAT'({sr_l, issue & (&cnt)});
      done_o <= pop & m_last_o;
    end
  end
  fft_sync_fifo #(.W(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(sr_v[MUX_LAT-1]),
    .push_data({sr_l[MUX_LAT-1], mux_data_i}),
    .pop(pop),
    .pop_data(head),
    .empty(empty),
    .count(occ)
  );
endmodule

// File: tb/tb_fft_mux_seq_ctrl.sv
// tb_fft_mux_seq_ctrl: table-driven frame scenarios with random backpressure, checked
// against an expected-index queue, plus reset and back-to-back sequences.
module tb_fft_mux_seq_ctrl;
  localparam int DW = 8, SW = 8, LAT = 2, FD = 4, N = 256;
  typedef struct {
    bit rev;
    int pct;
    bit poke;
    int exp_first;
    int exp_done;
  } vec_t;
  logic clk = 0, rst_n = 1, start_i = 0, bitrev_i = 0, m_ready_i = 1;
  logic [SW-1:0] sel_o, d1, d2;
  logic [DW-1:0] mux_data_i, m_data_o;
  logic m_valid_o, m_last_o, busy_o, done_o;
  int pass_cnt = 0, total = 0, beats = 0, dones = 0, stall_left = 0, max_occ = 0;
  int exp_q[$];
  logic prev_stall = 0;
  logic [DW+1:0] prev_word;
  vec_t vecs[6];

  always #5 clk = ~clk;
  // Registered external mux: returns the selected index MUX_LAT cycles after sel_o.
  always @(posedge clk) begin
    d1 <= sel_o;
    d2 <= d1;
  end
  assign mux_data_i = d2;

  fft_mux_seq_ctrl #(.DATA_WIDTH(DW), .SEL_W(SW), .MUX_LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .bitrev_i(bitrev_i), .sel_o(sel_o),
    .mux_data_i(mux_data_i), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_last_o(m_last_o), .busy_o(busy_o), .done_o(done_o));

  function automatic int rev8(int k);
    int r = 0;
    for (int b = 0; b < SW; b++) begin
      r = r * 2 + k % 2;
      k = k / 2;
    end
    return r;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fill(bit rev);
    for (int k = 0; k < N; k++) exp_q.push_back(rev ? rev8(k) : k);
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_sel"}, int'(sel_o), 0);
    check({tag, "_valid"}, int'(m_valid_o), 0);
    check({tag, "_last"}, int'(m_last_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_done"}, int'(done_o), 0);
    check({tag, "_data"}, int'(m_data_o), 0);
  endtask

  task automatic drive_ready(int pct);
    if (stall_left > 0) begin
      stall_left--;
      m_ready_i = 0;
    end else if (int'($urandom_range(99, 0)) < pct) begin
      stall_left = int'($urandom_range(19, 0));
      m_ready_i = 0;
    end else m_ready_i = 1;
  endtask

  // Stream monitor: order, last flag, stall stability, buffer occupancy bound.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) check("stall_hold", int'({m_valid_o, m_last_o, m_data_o}), int'(prev_word));
      if (m_valid_o && m_ready_i) begin
        beats++;
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          check("beat_data", int'(m_data_o), exp_q[0]);
          check("beat_last", int'(m_last_o), int'(exp_q.size() == 1));
          void'(exp_q.pop_front());
        end
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_word = {m_valid_o, m_last_o, m_data_o};
      if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
    end else prev_stall = 0;
  end

  task automatic run_frame(input vec_t v);
    int first = -1, done_at = -1, extra = 0;
    beats = 0; dones = 0; max_occ = 0; stall_left = 0;
    fill(v.rev);
    bitrev_i = v.rev; start_i = 1; m_ready_i = 1;
    @(posedge clk); #1 start_i = 0;
    for (int i = 1; i < 5000 && extra < 4; i++) begin
      start_i = v.poke && i == 50;
      drive_ready(v.pct);
      @(posedge clk); #1;
      if (m_valid_o && first < 0) first = i;
      if (done_o) begin
        dones++;
        check("busy_at_done", int'(busy_o), 0);
        if (done_at < 0) done_at = i;
      end
      if (done_at >= 0) extra++;
    end
    start_i = 0; m_ready_i = 1;
    check("first_latency", first, v.exp_first);
    if (v.exp_done >= 0) check("done_cycle", done_at, v.exp_done);
    check("frame_done", int'(done_at >= 0), 1);
    check("beat_count", beats, N);
    check("done_count", dones, 1);
    check("missing_beats", exp_q.size(), 0);
    check("occ_bound", int'(max_occ <= FD), 1);
    check("idle_after", int'(busy_o), 0);
    exp_q.delete();
  endtask

  initial begin
    int first, d1st, d2nd;
    vecs[0] = '{0, 0, 0, LAT + 1, N + LAT + 1};
    vecs[1] = '{1, 0, 0, LAT + 1, N + LAT + 1};
    vecs[2] = '{0, 30, 0, LAT + 1, -1};
    vecs[3] = '{1, 30, 0, LAT + 1, -1};
    vecs[4] = '{0, 0, 1, LAT + 1, N + LAT + 1};
    vecs[5] = '{1, 60, 1, LAT + 1, -1};
    #1 rst_n = 0;
    #1 chk_zero("por");
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    for (int t = 0; t < 6; t++) run_frame(vecs[t]);

    // Reset in the middle of a frame, then a fresh frame must begin at index 0.
    beats = 0;
    fill(0);
    bitrev_i = 0; start_i = 1; m_ready_i = 1;
    @(posedge clk); #1 start_i = 0;
    for (int i = 0; i < 400 && beats < 100; i++) begin
      @(posedge clk); #1;
    end
    check("reach_beat100", int'(beats >= 100), 1);
    rst_n = 0;
    #1 chk_zero("rst_mid");
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1 chk_zero("post_rst");
    run_frame(vecs[0]);

    // Back-to-back: next start issued in the done_o cycle.
    beats = 0; dones = 0; first = -1; d1st = -1; d2nd = -1;
    fill(0);
    bitrev_i = 0; start_i = 1; m_ready_i = 1;
    @(posedge clk); #1 start_i = 0;
    for (int i = 1; i < 2000 && dones < 2; i++) begin
      @(posedge clk); #1;
      start_i = 0;
      if (done_o) begin
        dones++;
        if (dones == 1) begin
          fill(1);
          bitrev_i = 1; start_i = 1; d1st = i;
        end else d2nd = i;
      end
      if (d1st >= 0 && i > d1st && m_valid_o && first < 0) first = i - d1st - 1;
    end
    check("b2b_latency", first, LAT + 1);
    check("b2b_period", d2nd - d1st, N + LAT + 2);
    check("b2b_beats", beats, 2 * N);
    check("b2b_dones", dones, 2);
    check("b2b_missing", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 check("b2b_idle", int'(busy_o), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/fft_mux_seq_ctrl.md
FFT_MUX_SEQ_CTRL -- requirements
Module: fft_mux_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, sample width.
REQ-002 SHALL have parameter SEL_W, default 8, select width; frame length N = 2**SEL_W (256 by default).
REQ-003 SHALL have parameter MUX_LAT, default 2, cycles from sel_o to the matching mux_data_i.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries; must be >= MUX_LAT+1.
REQ-005 SHALL have port clk  input  1  rising-edge clock; single clock domain.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start_i  input  1  frame start request, sampled in IDLE only.
REQ-008 SHALL have port bitrev_i  input  1  bit-reversed select order, latched on an accepted start.
REQ-009 SHALL have port sel_o  output  SEL_W  select driven to the external N:1 mux.
REQ-010 SHALL have port mux_data_i  input  DATA_WIDTH  registered mux output, valid MUX_LAT cycles after sel_o.
REQ-011 SHALL have port m_data_o  output  DATA_WIDTH  stream data.
REQ-012 SHALL have port m_valid_o  output  1  stream valid.
REQ-013 SHALL have port m_ready_i  input  1  stream ready.
REQ-014 SHALL have port m_last_o  output  1  asserted on the frame's final beat.
REQ-015 SHALL have port busy_o  output  1  high in RUN and DRAIN.
REQ-016 SHALL have port done_o  output  1  one-cycle pulse after the last beat's handshake.

Function
REQ-017 SHALL implement FSM IDLE -> RUN on start_i=1; RUN -> DRAIN when index N-1 is issued; DRAIN -> IDLE on the m_last_o handshake.
REQ-018 SHALL ignore start_i in RUN and DRAIN, with no queuing.
REQ-019 SHALL keep an SEL_W-bit issue counter, cleared on an accepted start and incremented per issue; sel_o = counter, or its bit-reverse when the latched bitrev is 1.
REQ-020 SHALL issue at most one index per cycle, in RUN only, and only when FIFO occupancy + in-flight count < FIFO_DEPTH (credit rule).
REQ-021 SHALL hold sel_o stable on non-issue cycles, so the mux output is never consumed for those cycles.
REQ-022 SHALL track in-flight issues in a MUX_LAT-deep shift register of {valid, last}; entries at the tail SHALL push mux_data_i and last into the FIFO.
REQ-023 SHALL ensure the FIFO never overflows; a push on a full FIFO is a design error, checked by assertion.
REQ-024 SHALL drive m_valid_o = FIFO not empty and m_data_o/m_last_o = FIFO head; the head SHALL pop on m_valid_o & m_ready_i.
REQ-025 SHALL hold m_data_o and m_last_o stable while m_valid_o=1 and m_ready_i=0.
REQ-026 SHALL allow simultaneous push and pop in one cycle, leaving occupancy unchanged.
REQ-027 SHALL give a latency of MUX_LAT+1 cycles from start accept to the first m_valid_o, under continuous m_ready_i=1.
REQ-028 SHALL sustain one beat per cycle under continuous m_ready_i=1, delivering a frame in N+MUX_LAT+1 cycles.
REQ-029 SHALL assert done_o in the cycle after the m_last_o handshake; busy_o SHALL be low in that same cycle.
REQ-030 SHALL allow a start_i in the done_o cycle to be accepted as the next frame.

Reset
REQ-031 SHALL on rst_n=0, immediately and asynchronously set state=IDLE, counter=0, sel_o=0, shift register cleared, FIFO empty, and m_valid_o, m_last_o, busy_o, done_o = 0; m_data_o SHALL be 0.
REQ-032 SHALL discard any frame in progress on reset, with no partial done_o; the first start after release SHALL begin at index 0.

Structure
REQ-033 SHALL place the state enum type (IDLE, RUN, DRAIN) and the bit-reverse function in shared package fft_ctrl_pkg.
REQ-034 SHALL implement the output buffer as sub-module fft_sync_fifo, parameterised by DATA_WIDTH+1 and FIFO_DEPTH.
REQ-035 SHALL target fft_mux_256x1 by default (SEL_W=8, MUX_LAT=2).

Verification
REQ-036 SHALL check a linear frame: bench mux returns data = index; start with ready=1 -> beats 0..255 in consecutive cycles, m_last_o on 255, done_o one cycle later.
REQ-037 SHALL check bit-reversed order: bitrev_i=1 -> stream 0,128,64,192,32,... and final beat 255.
REQ-038 SHALL check backpressure: ready randomly held low for 1-20 cycles -> no loss or duplication, data stable while stalled, FIFO occupancy never above 4.
REQ-039 SHALL check start in RUN: start_i pulse mid-frame -> ignored, exactly 256 beats and one done_o.
REQ-040 SHALL check reset mid-frame: rst_n low at beat 100 -> all outputs 0 at once; a new start yields index 0 first.
REQ-041 SHALL check back-to-back frames: start in the done_o cycle -> second frame's first beat MUX_LAT+1 cycles later, no gap artefacts.
